// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated load/store responder with byte/half/word lanes and sign extension
module dmem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CPU_MIO,
    input  logic        mem_w,
    input  logic [31:0] Addr_in,
    input  logic [31:0] Data_in,
    input  logic [2:0]  DMType,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic [ADDR_W+1:0]   lat_addr;
    logic [31:0]         lat_data;
    logic                lat_w;
    logic [2:0]          lat_type;
    logic [31:0]         mem [2**ADDR_W];

    logic                accept;
    logic                enter_resp;
    logic [ADDR_W+1:0]   sel_addr;
    logic [2:0]          sel_type;
    logic                sel_w;
    logic [31:0]         rd_word;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [31:0]         ld_data;
    logic                reject;
    logic [3:0]          wr_be;
    logic [31:0]         wr_data;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^Addr_in[31:ADDR_W+2];

    // In IDLE the request is still on the bus; afterwards only the latched copy counts.
    assign sel_addr = (state == IDLE) ? Addr_in[ADDR_W+1:0] : lat_addr;
    assign sel_type = (state == IDLE) ? DMType : lat_type;
    assign sel_w    = (state == IDLE) ? mem_w  : lat_w;
    assign rd_word  = mem[sel_addr[ADDR_W+1:2]];
    assign rd_byte  = rd_word[8*sel_addr[1:0] +: 8];
    assign rd_half  = sel_addr[1] ? rd_word[31:16] : rd_word[15:0];
    assign accept   = (state == IDLE) && CPU_MIO;

    always_comb begin
        reject  = 1'b0;
        ld_data = '0;
        wr_be   = 4'h0;
        wr_data = lat_data;
        case (sel_type)
            3'd0: begin
                reject  = (sel_addr[1:0] != 2'b00);
                ld_data = rd_word;
                wr_be   = 4'hF;
            end
            3'd1, 3'd2: begin
                reject  = sel_addr[0];
                ld_data = (sel_type == 3'd1) ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
                wr_be   = sel_addr[1] ? 4'hC : 4'h3;
                wr_data = {2{lat_data[15:0]}};
            end
            3'd3, 3'd4: begin
                ld_data = (sel_type == 3'd3) ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
                wr_be   = 4'b0001 << sel_addr[1:0];
                wr_data = {4{lat_data[7:0]}};
            end
            default: reject = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        MIO_ready = 1'b0;
        mem_err   = 1'b0;
        case (state)
            IDLE: if (CPU_MIO) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (cnt == 4'd0) state_nxt = RESP;
            RESP: begin
                state_nxt = IDLE;
                MIO_ready = 1'b1;
                mem_err   = reject;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign enter_resp = (state_nxt == RESP) && (state != RESP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            lat_addr <= '0;
            lat_data <= '0;
            lat_w    <= 1'b0;
            lat_type <= 3'd0;
            Data_out <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt      <= CNT_LOAD;
                lat_addr <= Addr_in[ADDR_W+1:0];
                lat_data <= Data_in;
                lat_w    <= mem_w;
                lat_type <= DMType;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                Data_out <= (sel_w || reject) ? 32'h0 : ld_data;
            end
        end
    end

    // An asynchronous reset forces state to IDLE before the closing edge, so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (state == RESP && lat_w && !reject) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) mem[lat_addr[ADDR_W+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized bench for dmem_responder against a byte-array memory model
module tb_dmem_responder;

    localparam int AW   = 10;
    localparam int WC   = 2;
    localparam int MEMB = 4 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        CPU_MIO, mem_w;
    logic [31:0] Addr_in, Data_in;
    logic [2:0]  DMType;
    logic [31:0] Data_out;
    logic        MIO_ready, mem_err;

    logic        CPU_MIO_z, mem_w_z;
    logic [31:0] Addr_in_z, Data_in_z;
    logic [2:0]  DMType_z;
    logic [31:0] Data_out_z;
    logic        MIO_ready_z, mem_err_z;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  mb [MEMB];
    logic [31:0] last_do;
    logic        last_err;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w), .Addr_in(Addr_in),
        .Data_in(Data_in), .DMType(DMType), .Data_out(Data_out), .MIO_ready(MIO_ready),
        .mem_err(mem_err)
    );

    dmem_responder #(.ADDR_W(4), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO_z), .mem_w(mem_w_z), .Addr_in(Addr_in_z),
        .Data_in(Data_in_z), .DMType(DMType_z), .Data_out(Data_out_z), .MIO_ready(MIO_ready_z),
        .mem_err(mem_err_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] t);
        return (t == 3'd0) ? 4 : ((t <= 3'd2) ? 2 : 1);
    endfunction

    function automatic logic ref_bad(input logic [31:0] a, input logic [2:0] t);
        if (t > 3'd4) return 1'b1;
        return (a % acc_size(t)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] t);
        int base;
        logic [31:0] v;
        base = int'(a % MEMB);
        v = 0;
        for (int i = 0; i < acc_size(t); i++) v = v | (32'(mb[base + i]) << (8 * i));
        if (t == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF_0000;
        if (t == 3'd3 && v >= 32'h80)   v = v + 32'hFFFF_FF00;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
        int base;
        base = int'(a % MEMB);
        for (int i = 0; i < acc_size(t); i++) mb[base + i] = 8'(d >> (8 * i));
    endtask

    // Entered and left #1 after a rising edge with the DUT in IDLE.
    task automatic do_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [2:0] t, input string tag);
        logic        err_exp;
        logic [31:0] exp;
        int          lat;
        logic        stray;
        CPU_MIO = 1'b1; mem_w = w; Addr_in = a; Data_in = d; DMType = t;
        lat = 0;
        stray = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (!MIO_ready && mem_err) stray = 1'b1;
            if (!MIO_ready) begin
                mem_w = 1'($urandom); Addr_in = $urandom; Data_in = $urandom; DMType = 3'($urandom);
            end
        end while (!MIO_ready && lat < 40);
        CPU_MIO = 1'b0;
        err_exp = ref_bad(a, t);
        exp = (w || err_exp) ? 32'h0 : ref_load(a, t);
        last_do = Data_out;
        last_err = mem_err;
        check({tag, "_lat"}, lat, WC + 1);
        check({tag, "_data"}, Data_out, exp);
        check({tag, "_err"}, 32'(mem_err), 32'(err_exp));
        if (w && !err_exp) ref_store(a, d, t);
        @(posedge clk); #1;
        check({tag, "_after"}, {30'h0, stray, MIO_ready | mem_err}, 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] v1, v2;
        logic [2:0]  t;
        logic [31:0] zaddr [4];
        logic [31:0] zdata [4];
        logic        zw [4];
        logic [31:0] zexp [4];

        reset = 1'b1;
        CPU_MIO = 1'b0; mem_w = 1'b0; Addr_in = '0; Data_in = '0; DMType = '0;
        CPU_MIO_z = 1'b0; mem_w_z = 1'b0; Addr_in_z = '0; Data_in_z = '0; DMType_z = '0;
        #1;
        check("rst_out", {Data_out[29:0], MIO_ready, mem_err}, 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        check("rst_idle", {Data_out[29:0], MIO_ready, mem_err}, 32'h0);

        for (int i = 0; i < MEMB / 4; i++) do_access(1'b1, 32'(i * 4), $urandom, 3'd0, "preload");

        do_access(1'b1, 32'h10, 32'hDEADBEEF, 3'd0, "st_word");
        do_access(1'b0, 32'h10, 32'h0, 3'd0, "ld_word");
        check("ld_word_k", last_do, 32'hDEADBEEF);

        do_access(1'b1, 32'h20, 32'h0, 3'd0, "st_w20");
        do_access(1'b1, 32'h23, 32'h80, 3'd3, "st_b23");
        do_access(1'b0, 32'h23, 32'h0, 3'd3, "ld_bs");
        check("ld_bs_k", last_do, 32'hFFFFFF80);
        do_access(1'b0, 32'h23, 32'h0, 3'd4, "ld_bu");
        check("ld_bu_k", last_do, 32'h00000080);
        do_access(1'b0, 32'h20, 32'h0, 3'd0, "ld_w20");
        check("ld_w20_k", last_do, 32'h80000000);

        do_access(1'b1, 32'h42, 32'h1234ABCD, 3'd1, "st_h42");
        do_access(1'b0, 32'h40, 32'h0, 3'd0, "ld_w40");
        check("ld_w40_k", {16'h0, last_do[31:16]}, 32'h0000ABCD);
        do_access(1'b0, 32'h42, 32'h0, 3'd1, "ld_hs");
        check("ld_hs_k", last_do, 32'hFFFFABCD);
        do_access(1'b0, 32'h42, 32'h0, 3'd2, "ld_hu");
        check("ld_hu_k", last_do, 32'h0000ABCD);

        do_access(1'b0, 32'h41, 32'h0, 3'd0, "rej_w41");
        check("rej_w41_k", {last_do[30:0], last_err}, 32'h1);
        do_access(1'b1, 32'h43, 32'hFFFFFFFF, 3'd1, "rej_h43");
        check("rej_h43_k", 32'(last_err), 32'h1);
        do_access(1'b0, 32'h40, 32'h0, 3'd0, "rej_h43_mem");
        do_access(1'b0, 32'h40, 32'h0, 3'd7, "rej_t7");
        check("rej_t7_k", 32'(last_err), 32'h1);

        // Reset in the middle of a store's wait states.
        CPU_MIO = 1'b1; mem_w = 1'b1; Addr_in = 32'h0; Data_in = 32'h55AA55AA; DMType = 3'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("midrst_out", {Data_out[29:0], MIO_ready, mem_err}, 32'h0);
        CPU_MIO = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midrst_rdy", {30'h0, MIO_ready, mem_err}, 32'h0);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_idle", {30'h0, MIO_ready, mem_err}, 32'h0);
        do_access(1'b0, 32'h0, 32'h0, 3'd0, "midrst_ld");

        for (int i = 0; i < 400; i++) begin
            t = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            a = $urandom;
            if ($urandom_range(0, 3) != 0 && t <= 3'd4) a = a & ~32'(acc_size(t) - 1);
            do_access(1'($urandom), a, $urandom, t, "rnd");
        end

        // Zero-wait instance with CPU_MIO held high; 64 aliases to 0 with a 16-word store.
        v1 = $urandom;
        v2 = $urandom;
        zw[0] = 1'b1; zaddr[0] = 32'd64; zdata[0] = v1; zexp[0] = 32'h0;
        zw[1] = 1'b0; zaddr[1] = 32'd0;  zdata[1] = 0;  zexp[1] = v1;
        zw[2] = 1'b1; zaddr[2] = 32'd0;  zdata[2] = v2; zexp[2] = 32'h0;
        zw[3] = 1'b0; zaddr[3] = 32'd64; zdata[3] = 0;  zexp[3] = v2;
        CPU_MIO_z = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_w_z = zw[i]; Addr_in_z = zaddr[i]; Data_in_z = zdata[i]; DMType_z = 3'd0;
            if (i != 0) begin
                @(posedge clk); #1;
                check("z_gap", {30'h0, MIO_ready_z, mem_err_z}, 32'h0);
            end
            @(posedge clk); #1;
            check("z_rdy", {30'h0, MIO_ready_z, mem_err_z}, 32'h2);
            check("z_data", Data_out_z, zexp[i]);
        end
        CPU_MIO_z = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("z_idle", {30'h0, MIO_ready_z, mem_err_z}, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipeline CPU's memory port. It accepts load/store requests on the CPU_MIO/MIO_ready handshake, inserts a configurable number of wait states, and performs byte, halfword or word access with DMType-driven sign/zero extension. It returns read data on the CPU's Data_in bus, sits between the CPU core and on-chip RAM, and replaces a zero-latency combinational memory.

## Interface
- ADDR_W, 10: word-address width; storage is 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2: wait states inserted per access (0–15).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- CPU_MIO  in  1  request valid from the CPU; Addr_in, Data_in, mem_w and DMType are stable while it is high and MIO_ready is low.
- mem_w  in  1  1 = store, 0 = load.
- Addr_in  in  32  byte address (the CPU's Addr_out).
- Data_in  in  32  store data (the CPU's Data_out); the low byte or halfword is used for narrow stores.
- DMType  in  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101–111 are invalid.
- Data_out  out  32  load data (the CPU's Data_in); registered.
- MIO_ready  out  1  one-cycle completion pulse.
- mem_err  out  1  asserted with MIO_ready when the access was rejected.

## Operation
- FSM states: IDLE, WAIT, RESP.
  - IDLE → WAIT when CPU_MIO=1 and WAIT_CYCLES>0. Load the counter with WAIT_CYCLES−1 and latch the request fields.
  - IDLE → RESP when CPU_MIO=1 and WAIT_CYCLES=0, latching the request fields.
  - WAIT: decrement the counter; go to RESP when the counter is 0.
  - RESP: MIO_ready=1 for exactly this cycle, then go to IDLE unconditionally.
- Word index: latched Addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 2^(ADDR_W+2).
- Reject conditions:
  - word access with Addr[1:0]≠0;
  - halfword access with Addr[0]=1;
  - DMType 101–111.
  - On reject: no write, Data_out=0, mem_err=1 during RESP.
- Store: the write is committed at the rising edge that ends RESP.
  - Byte store writes Data_in[7:0] into lane Addr[1:0].
  - Halfword store writes Data_in[15:0] into lane Addr[1].
  - Other lanes are untouched.
  - Data_out is 0 during a store RESP.
- Load: Data_out is loaded on the edge entering RESP with the selected lane, extended per DMType.
  - Signed variants replicate bit 7 or bit 15; unsigned variants zero-fill.
- Data_out holds its value until the next entry into RESP.
- Storage contents are not cleared by reset. Initial contents are undefined; the bench preloads them.

## Timing
- Request first seen high in cycle n → MIO_ready high in cycle n+1+WAIT_CYCLES.
- Latency is 1 cycle at WAIT_CYCLES=0 and 3 cycles at the default.
- If CPU_MIO is still high in the IDLE cycle after RESP, it is a new request. Back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- Request inputs are sampled only on the IDLE→WAIT/RESP edge. Changes during WAIT are ignored.
- Reset values: state IDLE, counter 0, Data_out 0, MIO_ready 0, mem_err 0.
- Reset asserted mid-access (WAIT or RESP before its closing edge) aborts the access: no write and no MIO_ready. Deasserting reset returns to IDLE.
- MIO_ready and mem_err are never high outside RESP.

## Test plan
- Word store then load, WAIT_CYCLES=2:
  - store 0xDEADBEEF at 0x0000_0010; MIO_ready pulses exactly 3 cycles after request.
  - load word at 0x10 → Data_out=0xDEADBEEF, mem_err=0.
- Byte lanes and extension:
  - preload word at 0x20 with 0x00000000, then byte-store 0x80 to 0x23.
  - signed byte load at 0x23 → 0xFFFFFF80; unsigned → 0x00000080; word load at 0x20 → 0x80000000.
- Halfword: store 0x1234ABCD as halfword to 0x42.
  - word at 0x40 upper half = 0xABCD.
  - signed half load at 0x42 → 0xFFFFABCD; unsigned → 0x0000ABCD.
- Rejects:
  - word load at 0x41 → mem_err=1, Data_out=0.
  - halfword store at 0x43 → mem_err=1, memory unchanged.
  - DMType=111 → mem_err=1.
- Reset mid-access: start a word store of 0x55AA55AA at 0x0; assert reset during WAIT.
  - MIO_ready stays 0 and all outputs go to 0.
  - after release, a load at 0x0 returns the prior preloaded value.
- WAIT_CYCLES=0 with CPU_MIO held high: MIO_ready pulses every 2nd cycle; a write to address 1<<(ADDR_W+2) aliases to address 0.
